// File: rtl/fault_response_checker.sv
// Stores a golden response pass, compares later fault passes step by step against it,
// and emits one result record per fault pass over a valid/ready channel.
module fault_response_checker #(
  parameter int               OBS_W     = 30,
  parameter int               STEPS     = 1024,
  parameter int               STEP_W    = 10,
  parameter int               FID_W     = 16,
  parameter int               CNT_W     = 11,
  parameter logic [OBS_W-1:0] MISR_POLY = 30'h20000029
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pass_start,
  input  logic              pass_golden,
  input  logic [FID_W-1:0]  pass_fid,
  input  logic              smp_valid,
  input  logic [OBS_W-1:0]  smp_data,
  input  logic              pass_end,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [FID_W-1:0]  res_fid,
  output logic              res_detected,
  output logic [STEP_W-1:0] res_first_step,
  output logic [CNT_W-1:0]  res_fail_cnt,
  output logic [OBS_W-1:0]  res_sig,
  output logic              golden_ok,
  output logic              busy,
  output logic              err_seq,
  output logic              err_overflow
);
  // One extra bit so the counter can hold STEPS itself (the "pass full" value).
  localparam int SC_W = STEP_W + 1;
  localparam logic [SC_W-1:0] STEPS_C = SC_W'(STEPS);

  typedef enum logic [1:0] {IDLE, GOLD, CMP} state_t;

  state_t            state_q;
  logic [OBS_W-1:0]  mem [STEPS];
  logic [OBS_W-1:0]  rd_q;
  logic [SC_W-1:0]   step_q, step_d, gold_len_q;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [STEP_W-1:0] first_step_q, first_step_d;
  logic [OBS_W-1:0]  misr_q, misr_d, gold_sig_q;
  logic [FID_W-1:0]  fid_q;
  logic              res_valid_q, res_detected_q, golden_ok_q, err_seq_q, err_overflow_q;
  logic [FID_W-1:0]  res_fid_q;
  logic [STEP_W-1:0] res_first_step_q;
  logic [CNT_W-1:0]  res_fail_cnt_q;
  logic [OBS_W-1:0]  res_sig_q;
  logic              busy_w, take, overrun, mismatch, res_load_ok;

  assign busy_w   = (state_q != IDLE);
  assign take     = smp_valid && busy_w && !pass_start && (step_q != STEPS_C);
  assign overrun  = smp_valid && busy_w && !pass_start && (step_q == STEPS_C);
  // rd_q already holds mem[step_q]: the read address runs one step ahead.
  assign mismatch = (state_q == CMP) && ((step_q >= gold_len_q) || (smp_data != rd_q));
  assign res_load_ok = !res_valid_q || res_ready;

  always_comb begin
    step_d       = step_q;
    fail_cnt_d   = fail_cnt_q;
    first_step_d = first_step_q;
    misr_d       = misr_q;
    if (pass_start) begin
      step_d       = '0;
      fail_cnt_d   = '0;
      first_step_d = '0;
      misr_d       = '0;
    end else if (take) begin
      step_d = step_q + SC_W'(1);
      misr_d = {misr_q[OBS_W-2:0], 1'b0} ^ (misr_q[OBS_W-1] ? MISR_POLY : '0) ^ smp_data;
      if (mismatch) begin
        if (fail_cnt_q == '0) first_step_d = step_q[STEP_W-1:0];
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == GOLD) && take) mem[step_q[STEP_W-1:0]] <= smp_data;
    rd_q <= mem[step_d[STEP_W-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      step_q           <= '0;
      fail_cnt_q       <= '0;
      first_step_q     <= '0;
      misr_q           <= '0;
      gold_len_q       <= '0;
      gold_sig_q       <= '0;
      fid_q            <= '0;
      golden_ok_q      <= 1'b0;
      err_seq_q        <= 1'b0;
      err_overflow_q   <= 1'b0;
      res_valid_q      <= 1'b0;
      res_fid_q        <= '0;
      res_detected_q   <= 1'b0;
      res_first_step_q <= '0;
      res_fail_cnt_q   <= '0;
      res_sig_q        <= '0;
    end else begin
      step_q       <= step_d;
      fail_cnt_q   <= fail_cnt_d;
      first_step_q <= first_step_d;
      misr_q       <= misr_d;
      if (res_valid_q && res_ready) res_valid_q <= 1'b0;
      if ((smp_valid && !busy_w) || overrun) err_seq_q <= 1'b1;
      if (pass_start) begin
        fid_q <= pass_fid;
        if (busy_w) err_seq_q <= 1'b1;
        if (pass_golden) begin
          state_q     <= GOLD;
          golden_ok_q <= 1'b0;
        end else if (golden_ok_q) begin
          state_q <= CMP;
        end else begin
          state_q   <= IDLE;
          err_seq_q <= 1'b1;
        end
      end else if (pass_end) begin
        case (state_q)
          GOLD: begin
            state_q     <= IDLE;
            gold_len_q  <= step_d;
            gold_sig_q  <= misr_d;
            golden_ok_q <= 1'b1;
          end
          CMP: begin
            state_q <= IDLE;
            if (res_load_ok) begin
              res_valid_q      <= 1'b1;
              res_fid_q        <= fid_q;
              res_detected_q   <= (fail_cnt_d != '0) || (step_d != gold_len_q);
              res_first_step_q <= first_step_d;
              res_fail_cnt_q   <= fail_cnt_d;
              res_sig_q        <= misr_d;
            end else begin
              err_overflow_q <= 1'b1;
            end
          end
          default: err_seq_q <= 1'b1;
        endcase
      end
    end
  end

  assign busy           = busy_w;
  assign golden_ok      = golden_ok_q;
  assign err_seq        = err_seq_q;
  assign err_overflow   = err_overflow_q;
  assign res_valid      = res_valid_q;
  assign res_fid        = res_fid_q;
  assign res_detected   = res_detected_q;
  assign res_first_step = res_first_step_q;
  assign res_fail_cnt   = res_fail_cnt_q;
  assign res_sig        = res_sig_q;
endmodule

// File: tb/tb_fault_response_checker.sv
// Directed bench for fault_response_checker with an 8-step golden memory.
module tb_fault_response_checker;
  localparam int OBS_W = 30;
  localparam int STEPS = 8;
  localparam int STEP_W = 3;
  localparam int FID_W = 16;
  localparam int CNT_W = 11;
  localparam logic [OBS_W-1:0] POLY = 30'h20000029;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pass_start = 1'b0;
  logic              pass_golden = 1'b0;
  logic [FID_W-1:0]  pass_fid = '0;
  logic              smp_valid = 1'b0;
  logic [OBS_W-1:0]  smp_data = '0;
  logic              pass_end = 1'b0;
  logic              res_ready = 1'b0;
  logic              res_valid, res_detected, golden_ok, busy, err_seq, err_overflow;
  logic [FID_W-1:0]  res_fid;
  logic [STEP_W-1:0] res_first_step;
  logic [CNT_W-1:0]  res_fail_cnt;
  logic [OBS_W-1:0]  res_sig;

  int checks = 0;
  int errors = 0;
  logic rv_at_end;
  logic [OBS_W-1:0] gold_sig_exp;

  fault_response_checker #(
    .OBS_W(OBS_W), .STEPS(STEPS), .STEP_W(STEP_W), .FID_W(FID_W), .CNT_W(CNT_W), .MISR_POLY(POLY)
  ) dut (
    .clk(clk), .rst(rst), .pass_start(pass_start), .pass_golden(pass_golden),
    .pass_fid(pass_fid), .smp_valid(smp_valid), .smp_data(smp_data), .pass_end(pass_end),
    .res_valid(res_valid), .res_ready(res_ready), .res_fid(res_fid),
    .res_detected(res_detected), .res_first_step(res_first_step),
    .res_fail_cnt(res_fail_cnt), .res_sig(res_sig), .golden_ok(golden_ok),
    .busy(busy), .err_seq(err_seq), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OBS_W-1:0] sample(input int i, input logic [7:0] flip);
    return OBS_W'(i) ^ OBS_W'(flip[i]);
  endfunction

  function automatic logic [OBS_W-1:0] misr_model(input int n, input logic [7:0] flip);
    logic [OBS_W-1:0] m = '0;
    for (int i = 0; i < n; i++)
      m = {m[OBS_W-2:0], 1'b0} ^ (m[OBS_W-1] ? POLY : '0) ^ sample(i, flip);
    return m;
  endfunction

  // Full pass; when last_with_end is set the final sample shares its cycle with pass_end.
  task automatic do_pass(input bit golden, input int fid, input int n, input logic [7:0] flip,
                         input bit last_with_end);
    pass_start = 1'b1; pass_golden = golden; pass_fid = FID_W'(fid);
    tick();
    pass_start = 1'b0; pass_golden = 1'b0;
    for (int i = 0; i < n; i++) begin
      smp_valid = 1'b1; smp_data = sample(i, flip);
      if (last_with_end && i == n - 1) break;
      tick();
    end
    if (!last_with_end) smp_valid = 1'b0;
    pass_end = 1'b1;
    rv_at_end = res_valid;
    tick();
    pass_end = 1'b0; smp_valid = 1'b0;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_golden_ok", golden_ok, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err_seq", err_seq, 0);
    check_eq("rst_err_overflow", err_overflow, 0);
    rst = 1'b0;
    tick();

    // fault pass with no golden reference
    pass_start = 1'b1; pass_fid = 16'd3;
    tick();
    pass_start = 1'b0;
    check_eq("nogold_busy", busy, 0);
    check_eq("nogold_err_seq", err_seq, 1);
    tick();
    check_eq("nogold_res_valid", res_valid, 0);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    check_eq("rerst_err_seq", err_seq, 0);

    // golden pass 0..7
    pass_start = 1'b1; pass_golden = 1'b1;
    tick();
    pass_start = 1'b0; pass_golden = 1'b0;
    check_eq("gold_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      smp_valid = 1'b1; smp_data = OBS_W'(i); tick();
    end
    smp_valid = 1'b0; pass_end = 1'b1; tick(); pass_end = 1'b0;
    gold_sig_exp = misr_model(8, 8'h00);
    check_eq("gold_ok", golden_ok, 1);
    check_eq("gold_busy_end", busy, 0);
    check_eq("gold_no_result", res_valid, 0);

    // identical fault pass
    do_pass(1'b0, 5, 8, 8'h00, 1'b0);
    check_eq("f5_rv_at_end", rv_at_end, 0);
    check_eq("f5_res_valid", res_valid, 1);
    check_eq("f5_fid", res_fid, 5);
    check_eq("f5_detected", res_detected, 0);
    check_eq("f5_fail_cnt", res_fail_cnt, 0);
    check_eq("f5_first_step", res_first_step, 0);
    check_eq("f5_sig", res_sig, gold_sig_exp);
    consume();
    check_eq("f5_consumed", res_valid, 0);

    // bit 0 flipped at steps 3 and 6
    do_pass(1'b0, 9, 8, 8'b0100_1000, 1'b0);
    check_eq("f9_fid", res_fid, 9);
    check_eq("f9_detected", res_detected, 1);
    check_eq("f9_first_step", res_first_step, 3);
    check_eq("f9_fail_cnt", res_fail_cnt, 2);
    check_eq("f9_sig", res_sig, misr_model(8, 8'b0100_1000));
    check_eq("f9_sig_differs", res_sig != gold_sig_exp, 1);
    consume();

    // short pass, all matching
    do_pass(1'b0, 7, 6, 8'h00, 1'b0);
    check_eq("f7_detected", res_detected, 1);
    check_eq("f7_fail_cnt", res_fail_cnt, 0);
    check_eq("f7_first_step", res_first_step, 0);
    consume();

    // last (mismatching) sample arrives together with pass_end
    do_pass(1'b0, 11, 8, 8'b1000_0000, 1'b1);
    check_eq("f11_res_valid", res_valid, 1);
    check_eq("f11_detected", res_detected, 1);
    check_eq("f11_fail_cnt", res_fail_cnt, 1);
    check_eq("f11_first_step", res_first_step, 7);
    check_eq("f11_sig", res_sig, misr_model(8, 8'b1000_0000));
    consume();

    // overflow: two results with res_ready low
    do_pass(1'b0, 1, 8, 8'h00, 1'b0);
    do_pass(1'b0, 2, 8, 8'h02, 1'b0);
    check_eq("ovf_res_valid", res_valid, 1);
    check_eq("ovf_fid", res_fid, 1);
    check_eq("ovf_detected", res_detected, 0);
    check_eq("ovf_flag", err_overflow, 1);
    check_eq("ovf_err_seq", err_seq, 0);
    consume();
    check_eq("ovf_consumed", res_valid, 0);

    // asynchronous reset in the middle of a fault pass
    pass_start = 1'b1; pass_fid = 16'd4;
    tick();
    pass_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp_valid = 1'b1; smp_data = OBS_W'(i); tick();
    end
    smp_valid = 1'b0;
    check_eq("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_golden_ok", golden_ok, 0);
    check_eq("arst_err_overflow", err_overflow, 0);
    check_eq("arst_res_valid", res_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    pass_start = 1'b1; pass_fid = 16'd6;
    tick();
    pass_start = 1'b0;
    check_eq("post_err_seq", err_seq, 1);
    check_eq("post_busy", busy, 0);
    tick();
    check_eq("post_res_valid", res_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fault_response_checker.md
Name:
fault_response_checker

Overview:
- Observation-side counterpart to the fault-injection stimulus driver.
- Receives per-step DUT output samples for one golden pass, then for each fault pass (one per fault ID).
- Stores the golden response and compares every later pass step by step.
- Emits one result record per fault pass over a valid/ready channel: detected flag, first failing step, mismatch count and MISR signature.

Parameters:
- OBS_W, 30, width of the observed output sample (outport).
- STEPS, 1024, maximum samples per pass; golden memory depth.
- STEP_W, 10, step index width (clog2 STEPS).
- FID_W, 16, fault ID width.
- CNT_W, 11, mismatch counter width; saturates.
- MISR_POLY, 30'h20000029, MISR feedback polynomial, OBS_W bits.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- pass_start, input, 1, one-cycle pulse that opens a pass.
- pass_golden, input, 1, qualifies pass_start: 1 = golden pass, 0 = fault pass.
- pass_fid, input, FID_W, fault ID of the pass; sampled at pass_start.
- smp_valid, input, 1, a sample is present this cycle.
- smp_data, input, OBS_W, sample value.
- pass_end, input, 1, one-cycle pulse that closes the current pass.
- res_valid, output, 1, result record is valid.
- res_ready, input, 1, consumer accepts the record.
- res_fid, output, FID_W, fault ID of the record.
- res_detected, output, 1, the fault was detected.
- res_first_step, output, STEP_W, index of the first mismatching step; 0 when none.
- res_fail_cnt, output, CNT_W, number of mismatching steps; saturating.
- res_sig, output, OBS_W, MISR signature of the pass.
- golden_ok, output, 1, a golden reference is stored.
- busy, output, 1, a pass is in progress.
- err_seq, output, 1, sticky protocol-error flag.
- err_overflow, output, 1, sticky flag: a result was lost.

Behaviour:
- Reset: every output and internal register goes to 0; state = IDLE.
- States:
  - IDLE: pass_start with pass_golden=1 goes to GOLD. pass_start with pass_golden=0 goes to CMP if golden_ok=1; otherwise err_seq is set and the checker stays in IDLE.
  - GOLD: capturing the golden pass. pass_end goes to IDLE.
  - CMP: comparing a fault pass. pass_end goes to IDLE and emits a result.
  - busy = (state is GOLD or CMP).
- pass_start actions:
  - Clears step, fail_cnt, first_step and misr; latches pass_fid.
  - pass_start with pass_golden=1 clears golden_ok immediately.
- Sample acceptance: a sample is taken when smp_valid=1 in GOLD or CMP. smp_valid in IDLE is ignored and sets err_seq.
- Step counter:
  - Increments once per accepted sample.
  - A sample arriving when step==STEPS is discarded and sets err_seq; the counter does not wrap.
- MISR update on every accepted sample:
  - misr <= {misr[OBS_W-2:0],1'b0} ^ (misr[OBS_W-1] ? MISR_POLY : 0) ^ smp_data.
- GOLD:
  - Each sample writes mem[step] <= smp_data.
  - On pass_end: gold_len <= step; gold_sig <= misr; golden_ok <= 1; no result is emitted.
- CMP:
  - mismatch = (smp_data != mem[step]), evaluated combinationally in the same cycle.
  - A step >= gold_len counts as a mismatch.
  - On the first mismatch: first_step <= step.
  - fail_cnt increments on each mismatch and saturates at 2^CNT_W-1.
- Fault-pass end (pass_end in CMP):
  - detected = (fail_cnt_final != 0) || (step_final != gold_len).
  - res_sig = misr_final.
  - "final" values include any sample accepted in the same cycle as pass_end; that sample is processed before the pass closes.
- Result channel:
  - The result register is loaded 1 cycle after pass_end, with res_valid=1.
  - res_valid and all res_* fields hold stable until a cycle with res_valid && res_ready; res_valid drops on the next edge.
  - If a new result is ready while the held record is not being accepted that cycle, the new result is dropped, the held record is kept, and err_overflow is set.
  - If res_ready is high in the same cycle, the accept completes and the new record loads.
- pass_start while busy:
  - Sets err_seq; the old pass is abandoned with no result.
  - The new pass starts under the normal IDLE rules. A fault pass without golden_ok goes to IDLE.
- pass_end while in IDLE: ignored; sets err_seq.
- err_seq and err_overflow are cleared only by rst.
- Asynchronous rst during a pass aborts it and clears golden_ok; the golden pass must be rerun.

Test Plan:
- Reset, then golden pass with STEPS=8, samples 0..7. Fault pass fid=5 with identical samples -> res_valid one cycle after pass_end; res_fid=5, detected=0, fail_cnt=0, first_step=0, res_sig equals the golden signature.
- Fault pass fid=9 where steps 3 and 6 have bit 0 flipped -> detected=1, first_step=3, fail_cnt=2, res_sig differs from golden.
- Fault pass with only 6 samples, all matching -> detected=1 (length mismatch), fail_cnt=0.
- Fault pass issued before any golden pass -> no result, err_seq=1, busy=0.
- res_ready held low; two fault passes complete (fid=1, then fid=2) -> record shows fid=1, err_overflow=1. Raise res_ready -> fid=1 record is consumed, res_valid drops.
- rst asserted mid-fault-pass -> all outputs 0 asynchronously, golden_ok=0. A subsequent fault pass sets err_seq.
